vga_config_sequencer: RTL
=========================

// Module: vga_config_sequencer
// PURPOSE
//  Assembles SPI-received bytes into 32-bit VGA configuration packets and holds each one in a shadow register.
//  Commits the shadow to the live configuration only at frame_start, the start of vertical blank, so mode and
//  colour changes never tear mid-frame. Sits between SPI_Peripheral (byte side) and pixel_mux/char_memory
//  (config side). Returns a status byte that the SPI peripheral shifts out on MISO.
// PARAMETERS
//  SYNC_BYTE       8'h5A          header byte that opens a packet
//  CFG_RESET       32'h00FC_0000  config_out and shadow value after reset
//  TIMEOUT_CYCLES  4096           maximum clk cycles between bytes within one packet
// PORTS
//  clk            in   1   system clock
//  rst            in   1   synchronous reset, active-high
//  ss             in   1   SPI chip select, active-low; rising edge aborts any partial packet
//  byte_valid     in   1   1-cycle strobe: byte_data holds a complete received byte
//  byte_data      in   8   received byte
//  frame_start    in   1   1-cycle pulse at start of vertical blank
//  config_out     out  32  live configuration (bits [31:30] = pixel_mux select)
//  config_pending out  1   shadow holds an uncommitted packet
//  status_byte    out  8   {pending, err_sticky, state[1:0], 1'b0, frame_cnt[2:0]}
//  err_sticky     out  1   latched protocol error; cleared only by rst or a STAT_CLR packet
// BEHAVIOUR
//  - Reset (synchronous, rst=1 at a clk edge) sets:
//    config_out=shadow=CFG_RESET; pending=0; err_sticky=0; frame_cnt=0; state=IDLE; byte index=0; timer=0.
//  - State encoding: IDLE=0, DATA=1, CHK=2, DONE=3.
//  - IDLE: byte_valid with byte_data==SYNC_BYTE -> DATA, idx=0. Any other byte is ignored; no error.
//  - DATA: each byte_valid loads asm[31-8*idx -: 8] (MSB first), then idx++.
//    The byte at idx==3 -> CHK if CFG_CHECKSUM_EN is defined, else DONE.
//  - CHK: next byte_valid is compared with XOR of the 4 data bytes.
//    Match -> DONE. Mismatch -> IDLE, err_sticky=1, shadow unchanged.
//  - DONE: lasts exactly 1 cycle, then IDLE.
//    asm==32'hFFFF_FFFF is STAT_CLR: clears err_sticky, leaves shadow and pending unchanged.
//    Any other value: shadow<=asm, pending<=1.
//  - Timeout: timer counts cycles in DATA/CHK and resets on each byte_valid.
//    Reaching TIMEOUT_CYCLES -> IDLE, err_sticky=1.
//  - ss rising edge in DATA/CHK -> IDLE next cycle, err_sticky=1. ss edge in IDLE or DONE has no effect.
//  - Commit: frame_start while pending=1 -> config_out<=shadow, pending<=0, latency 1 cycle.
//    frame_start while pending=0 -> no change to config_out.
//  - Every frame_start increments frame_cnt, 3-bit and wrapping 7->0.
//  - frame_start in the same cycle as DONE (non-STAT_CLR) -> config_out<=asm directly and pending stays 0
//    (the new packet wins).
//  - A second packet completing while pending=1 overwrites the shadow (latest wins); pending stays 1.
//  - byte_valid in DONE is dropped; the sender leaves at least 1 idle cycle between packets.
//  - All outputs are registered. status_byte reflects state as of the previous clk edge.
// CONFIGURATION
//  CFG_CHECKSUM_EN defined: packet = SYNC + 4 data bytes + 1 XOR checksum byte; CHK state is used.
//  CFG_CHECKSUM_EN undefined: packet = SYNC + 4 data bytes; CHK is unreachable; a checksum mismatch can never
//  set err_sticky.
// TESTING
//  1. rst=1 for 2 cycles -> config_out=32'h00FC_0000, status_byte=8'h00, err_sticky=0.
//  2. Send 5A,C1,02,03,04 (+checksum C4 if EN), no frame_start -> pending=1, config_out unchanged.
//     Then pulse frame_start -> next cycle config_out=32'hC102_0304, pending=0.
//  3. Send 5A,11,22 then raise ss -> err_sticky=1, state=IDLE, shadow unchanged.
//     Then send 5A,FF,FF,FF,FF (+00 if EN) -> err_sticky=0.
//  4. Send 5A,11 then wait 4096 idle cycles -> err_sticky=1, status_byte[5:4]=0.
//  5. Align the last data byte so DONE coincides with frame_start
//     -> config_out updates 1 cycle later and pending never asserts.
//  6. EN only: send 5A,01,02,03,04,00 (bad checksum) -> err_sticky=1, pending=0, config_out unchanged.
//     Also pulse frame_start 9 times -> frame_cnt=1 (wrapped).

Source files
------------

// File: rtl/vga_config_sequencer.sv
// -----------------------------------------------------------------------------
// vga_config_sequencer
//
// Builds 32-bit VGA configuration packets from bytes delivered by the SPI
// peripheral. A packet starts with SYNC_BYTE and is followed by four data
// bytes, MSB first. A completed packet is held in a shadow register. The
// shadow is copied to the live configuration only on frame_start, which marks
// the start of vertical blank, so a frame never shows half-applied settings.
// The all-ones packet (STAT_CLR) clears the sticky error flag and does not
// touch the shadow.
//
// Build option:
//   CFG_CHECKSUM_EN  when defined, a packet carries a fifth XOR checksum byte
//                    after the data bytes. A bad checksum drops the packet
//                    and sets err_sticky.
//
// Ports:
//   clk             system clock
//   rst             synchronous reset, active-high
//   ss              SPI chip select, active-low; a rising edge aborts a packet
//   byte_valid      1-cycle strobe, byte_data holds a received byte
//   byte_data [7:0] received byte
//   frame_start     1-cycle pulse at start of vertical blank
//   config_out[31:0] live configuration ([31:30] = pixel_mux select)
//   config_pending  shadow holds a packet not yet committed
//   status_byte[7:0] {pending, err_sticky, state[1:0], 1'b0, frame_cnt[2:0]}
//   err_sticky      latched protocol error (abort, timeout, bad checksum)
// -----------------------------------------------------------------------------
module vga_config_sequencer #(
  parameter logic [7:0]  SYNC_BYTE      = 8'h5A,
  parameter logic [31:0] CFG_RESET      = 32'h00FC_0000,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ss,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        frame_start,
  output logic [31:0] config_out,
  output logic        config_pending,
  output logic [7:0]  status_byte,
  output logic        err_sticky
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CHK  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [1:0]           r_idx;
  logic [31:0]          r_asm;
  logic [31:0]          r_shadow;
  logic [31:0]          r_config;
  logic                 r_pending;
  logic                 r_err;
  logic [2:0]           r_frame_cnt;
  logic [7:0]           r_status;
  logic [TIMER_W-1:0]   r_timer;
  logic                 r_ss_q;

  logic                 w_collecting;
  logic                 w_ss_rise;
  logic                 w_timeout;
  logic                 w_stat_clr;
  logic                 w_load;
  logic                 w_err_set;
  logic                 w_timer_run;

  assign w_collecting = (r_state == ST_DATA) || (r_state == ST_CHK);
  assign w_ss_rise    = ss & ~r_ss_q;
  // The timer holds the number of idle cycles already spent in the packet,
  // so the idle cycle that would make it TIMEOUT_CYCLES ends the packet.
  assign w_timeout    = w_collecting && !byte_valid && (r_timer == TIMER_LAST);
  assign w_stat_clr   = (r_asm == 32'hFFFF_FFFF);

`ifdef CFG_CHECKSUM_EN
  logic [7:0] w_xor;
  assign w_xor = r_asm[31:24] ^ r_asm[23:16] ^ r_asm[15:8] ^ r_asm[7:0];
`endif

  // Next-state logic and per-cycle control strobes.
  // NOTE: every signal written here gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (byte_valid && (byte_data == SYNC_BYTE)) w_state_next = ST_DATA;
      end
      ST_DATA: begin
        if (w_ss_rise || w_timeout) begin
          w_state_next = ST_IDLE;
          w_err_set    = 1'b1;
        end else if (byte_valid) begin
          w_load = 1'b1;
          if (r_idx == 2'd3) begin
`ifdef CFG_CHECKSUM_EN
            w_state_next = ST_CHK;
`else
            w_state_next = ST_DONE;
`endif
          end
        end
      end
      ST_CHK: begin
`ifdef CFG_CHECKSUM_EN
        if (w_ss_rise || w_timeout) begin
          w_state_next = ST_IDLE;
          w_err_set    = 1'b1;
        end else if (byte_valid) begin
          if (byte_data == w_xor) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_IDLE;
            w_err_set    = 1'b1;
          end
        end
`else
        w_state_next = ST_IDLE;
`endif
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // The timer runs only while the packet stays in the same collecting state
  // without a byte. Any byte, exit or state change clears it.
  assign w_timer_run = w_collecting && !byte_valid && (w_state_next == r_state);

  // NOTE: state is updated with non-blocking assignments only, so every
  // register here sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= 2'd0;
      r_asm       <= 32'd0;
      r_shadow    <= CFG_RESET;
      r_config    <= CFG_RESET;
      r_pending   <= 1'b0;
      r_err       <= 1'b0;
      r_frame_cnt <= 3'd0;
      r_status    <= 8'h00;
      r_timer     <= '0;
      r_ss_q      <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_ss_q  <= ss;
      r_timer <= w_timer_run ? r_timer + 1'b1 : '0;

      if (r_state == ST_IDLE) r_idx <= 2'd0;
      else if (w_load)        r_idx <= r_idx + 2'd1;

      if (w_load) begin
        case (r_idx)
          2'd0:    r_asm[31:24] <= byte_data;
          2'd1:    r_asm[23:16] <= byte_data;
          2'd2:    r_asm[15:8]  <= byte_data;
          default: r_asm[7:0]   <= byte_data;
        endcase
      end

      if (w_err_set)                             r_err <= 1'b1;
      else if ((r_state == ST_DONE) && w_stat_clr) r_err <= 1'b0;

      if (frame_start) r_frame_cnt <= r_frame_cnt + 3'd1;

      // A packet finishing during frame_start goes live at once and
      // replaces any older pending packet.
      if ((r_state == ST_DONE) && !w_stat_clr) begin
        r_shadow <= r_asm;
        if (frame_start) begin
          r_config  <= r_asm;
          r_pending <= 1'b0;
        end else begin
          r_pending <= 1'b1;
        end
      end else if (frame_start && r_pending) begin
        r_config  <= r_shadow;
        r_pending <= 1'b0;
      end

      // The status byte is a snapshot of the registers as they were
      // before this edge.
      r_status <= {r_pending, r_err, r_state, 1'b0, r_frame_cnt};
    end
  end

  assign config_out     = r_config;
  assign config_pending = r_pending;
  assign err_sticky     = r_err;
  assign status_byte    = r_status;

endmodule
